dc_tag_responder: RTL

//  Responder end of the DC tag-search interface: owns the L1 D-cache tag array.
//  4-way set-associative, 32 sets.
//  - Lookup: compares the request tag across all ways; acks hit/way/state.
//    On miss, acks the RRIP victim way.
//  - Update: writes tag/state into a given way.

---
 rtl/dc_tag_pkg.sv | 45 ++++
 rtl/dc_tag_responder_if.sv | 26 ++
 rtl/dc_rrip_victim_sel.sv | 33 +++
 rtl/dc_tag_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dc_tag_pkg.sv
// Shared widths, encodings and entry layout for the DC tag responder.
package dc_tag_pkg;
  localparam int TAG_BITS  = 18;
  localparam int SET_BITS  = 5;
  localparam int WAYS      = 4;
  localparam int WAY_BITS  = 2;
  localparam int RRPV_BITS = 2;
  localparam int ST_BITS   = 3;
  localparam int ADDR_BITS = 29;
  localparam int SETS      = 1 << SET_BITS;
  localparam int TAG_LSB   = 11;
  localparam int SET_LSB   = 6;

  localparam logic [RRPV_BITS-1:0] RRPV_MAX = 2'd3;
  localparam logic [RRPV_BITS-1:0] RRPV_INS = 2'd2;
  localparam logic [RRPV_BITS-1:0] RRPV_HIT = 2'd0;

  typedef enum logic [ST_BITS-1:0] {
    ST_I  = 3'b000,
    ST_S  = 3'b001,
    ST_E  = 3'b010,
    ST_M  = 3'b011,
    ST_US = 3'b100
  } coh_state_e;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_UPDATE = 1'b1
  } req_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_AGE  = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [RRPV_BITS-1:0] rrpv;
    logic [ST_BITS-1:0]   state;
  } tag_entry_t;

  function automatic logic [RRPV_BITS-1:0] rrpv_age(input logic [RRPV_BITS-1:0] v);
    return (v == RRPV_MAX) ? v : v + RRPV_BITS'(1);
  endfunction
endpackage

// File: rtl/dc_tag_responder_if.sv
// Request/ack bundle between the tag-check initiator (master) and this responder (slave).
interface dc_tag_responder_if;
  import dc_tag_pkg::*;

  logic                 req_valid;
  logic                 req_retry;
  logic                 req_op;
  logic [ADDR_BITS-1:0] req_addr;
  logic [WAY_BITS-1:0]  req_way;
  logic [ST_BITS-1:0]   req_state;
  logic                 ack_valid;
  logic                 ack_retry;
  logic                 ack_hit;
  logic [WAY_BITS-1:0]  ack_way;
  logic [ST_BITS-1:0]   ack_state;

  modport master (
    output req_valid, req_op, req_addr, req_way, req_state, ack_retry,
    input  req_retry, ack_valid, ack_hit, ack_way, ack_state
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_way, req_state, ack_retry,
    output req_retry, ack_valid, ack_hit, ack_way, ack_state
  );
endinterface

// File: rtl/dc_rrip_victim_sel.sv
// RRIP victim pick for one set: lowest invalid way, else lowest way at distant RRPV.
module dc_rrip_victim_sel
  import dc_tag_pkg::*;
(
  input  logic [WAYS-1:0][ST_BITS-1:0]   i_state,
  input  logic [WAYS-1:0][RRPV_BITS-1:0] i_rrpv,
  output logic                           o_found,
  output logic [WAY_BITS-1:0]            o_way
);
  logic [WAYS-1:0] w_invalid;
  logic [WAYS-1:0] w_distant;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_invalid[gi] = (i_state[gi] == ST_I);
      assign w_distant[gi] = (i_rrpv[gi] == RRPV_MAX);
    end
  endgenerate

  always_comb begin
    o_found = (|w_invalid) || (|w_distant);
    o_way   = '0;
    if (|w_invalid) begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (w_invalid[i]) o_way = WAY_BITS'(i);
      end
    end else begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (w_distant[i]) o_way = WAY_BITS'(i);
      end
    end
  end
endmodule

// File: rtl/dc_tag_responder.sv
// Owns the 4-way x 32-set L1 D-cache tag array; answers lookup/update requests with RRIP replacement.
// Optional macro DC_TAG_STATS_EN adds saturating lookup counters on hit_cnt/miss_cnt.
module dc_tag_responder
  import dc_tag_pkg::*;
(
  input  logic clk,
  input  logic reset,
`ifdef DC_TAG_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  dc_tag_responder_if.slave tag_bus
);
  tag_entry_t          r_array [SETS][WAYS];
  fsm_state_e          r_fsm;
  fsm_state_e          w_fsm_next;
  logic [SET_BITS-1:0] r_age_set;
  logic                r_ack_valid;
  logic                r_ack_hit;
  logic [WAY_BITS-1:0] r_ack_way;
  logic [ST_BITS-1:0]  r_ack_state;

  logic [TAG_BITS-1:0]            w_req_tag;
  logic [SET_BITS-1:0]            w_req_set;
  logic [SET_BITS-1:0]            w_rd_set;
  logic                           w_req_retry;
  logic                           w_accept;
  logic                           w_is_update;
  tag_entry_t                     w_entry [WAYS];
  logic [WAYS-1:0]                w_match;
  logic [WAYS-1:0][ST_BITS-1:0]   w_vs_state;
  logic [WAYS-1:0][RRPV_BITS-1:0] w_vs_rrpv;
  logic                           w_hit;
  logic [WAY_BITS-1:0]            w_hit_way;
  logic                           w_vic_found;
  logic [WAY_BITS-1:0]            w_vic_way;
  logic                           w_ack_load;
  logic                           w_ack_hit;
  logic [WAY_BITS-1:0]            w_ack_way;
  logic [ST_BITS-1:0]             w_ack_state;
  logic                           w_lookup_hit;
  logic                           w_lookup_miss;
  logic                           w_unused;

  assign w_req_tag   = tag_bus.req_addr[TAG_LSB +: TAG_BITS];
  assign w_req_set   = tag_bus.req_addr[SET_LSB +: SET_BITS];
  assign w_unused    = ^tag_bus.req_addr[SET_LSB-1:0];
  assign w_rd_set    = (r_fsm == S_AGE) ? r_age_set : w_req_set;
  assign w_is_update = (tag_bus.req_op == OP_UPDATE);

  // While ageing, the victim search sees the post-increment RRPVs of the held set.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_entry[gi]    = r_array[w_rd_set][gi];
      assign w_match[gi]    = (w_entry[gi].state != ST_I) && (w_entry[gi].tag == w_req_tag);
      assign w_vs_state[gi] = w_entry[gi].state;
      assign w_vs_rrpv[gi]  = (r_fsm == S_AGE) ? rrpv_age(w_entry[gi].rrpv) : w_entry[gi].rrpv;
    end
  endgenerate

  assign w_hit = |w_match;
  always_comb begin
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_way = WAY_BITS'(i);
    end
  end

  dc_rrip_victim_sel u_victim_sel (
    .i_state (w_vs_state),
    .i_rrpv  (w_vs_rrpv),
    .o_found (w_vic_found),
    .o_way   (w_vic_way)
  );

  assign w_req_retry = !reset || (r_fsm != S_IDLE) || (r_ack_valid && tag_bus.ack_retry);
  assign w_accept    = tag_bus.req_valid && !w_req_retry;

  always_comb begin
    w_fsm_next    = r_fsm;
    w_ack_load    = 1'b0;
    w_ack_hit     = 1'b0;
    w_ack_way     = '0;
    w_ack_state   = '0;
    w_lookup_hit  = 1'b0;
    w_lookup_miss = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_update) begin
            w_ack_load  = 1'b1;
            w_ack_hit   = 1'b1;
            w_ack_way   = tag_bus.req_way;
            w_ack_state = tag_bus.req_state;
          end else if (w_hit) begin
            w_ack_load   = 1'b1;
            w_ack_hit    = 1'b1;
            w_ack_way    = w_hit_way;
            w_ack_state  = w_entry[w_hit_way].state;
            w_lookup_hit = 1'b1;
          end else if (w_vic_found) begin
            w_ack_load    = 1'b1;
            w_ack_way     = w_vic_way;
            w_ack_state   = w_entry[w_vic_way].state;
            w_lookup_miss = 1'b1;
          end else begin
            w_fsm_next = S_AGE;
          end
        end
      end
      S_AGE: begin
        if (w_vic_found) begin
          w_ack_load    = 1'b1;
          w_ack_way     = w_vic_way;
          w_ack_state   = w_entry[w_vic_way].state;
          w_lookup_miss = 1'b1;
          w_fsm_next    = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm     <= S_IDLE;
      r_age_set <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      if (w_accept) r_age_set <= w_req_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ack_valid <= 1'b0;
      r_ack_hit   <= 1'b0;
      r_ack_way   <= '0;
      r_ack_state <= '0;
    end else if (w_ack_load) begin
      r_ack_valid <= 1'b1;
      r_ack_hit   <= w_ack_hit;
      r_ack_way   <= w_ack_way;
      r_ack_state <= w_ack_state;
    end else if (r_ack_valid && !tag_bus.ack_retry) begin
      r_ack_valid <= 1'b0;
    end
  end

  // No bypass: a request in the next cycle reads what this edge writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_array[s][w] <= '{tag: '0, rrpv: RRPV_MAX, state: ST_I};
        end
      end
    end else if (r_fsm == S_AGE) begin
      for (int w = 0; w < WAYS; w++) begin
        r_array[r_age_set][w].rrpv <= w_vs_rrpv[w];
      end
    end else if (w_accept && w_is_update) begin
      r_array[w_req_set][tag_bus.req_way] <= '{
        tag:   w_req_tag,
        rrpv:  (tag_bus.req_state == ST_I) ? RRPV_MAX : RRPV_INS,
        state: tag_bus.req_state
      };
    end else if (w_accept && w_hit) begin
      r_array[w_req_set][w_hit_way].rrpv <= RRPV_HIT;
    end
  end

  assign tag_bus.req_retry = w_req_retry;
  assign tag_bus.ack_valid = r_ack_valid;
  assign tag_bus.ack_hit   = r_ack_hit;
  assign tag_bus.ack_way   = r_ack_way;
  assign tag_bus.ack_state = r_ack_state;

`ifdef DC_TAG_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lookup_hit && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_lookup_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_lookup_hit ^ w_lookup_miss;
`endif
endmodule
